// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the WISC decode-stage hazard logic: opcodes,
// controller state encodings and a small opcode classification helper.
package id_hazard_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  // Branches are the only instructions that consume the flag register in ID.
  function automatic logic reads_flags(input opcode_t op);
    return (op == OP_B) || (op == OP_BR);
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Bundle of the ID-stage hazard inputs and the pipeline enable outputs.
interface id_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [15:0]      instr_id;
  logic             noop_id;
  logic [3:0]       reg_addr_ex;
  logic             mem_read_ex;
  logic             flag_set_ex;
  logic             noop_ex;
  logic             br_taken_id;
  logic             mem_busy;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_noop;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output instr_id, noop_id, reg_addr_ex, mem_read_ex, flag_set_ex, noop_ex,
           br_taken_id, mem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_noop, halted, stall_cnt
  );

  modport slave (
    input  instr_id, noop_id, reg_addr_ex, mem_read_ex, flag_set_ex, noop_ex,
           br_taken_id, mem_busy,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_noop, halted, stall_cnt
  );
endinterface

// File: rtl/id_hazard_ctrl_src_reg_decode.sv
// Source-register decode for the instruction in ID. Shared with the
// forwarding unit, so it reports every register read, including the SW
// data register; callers decide which reads matter to them.
import id_hazard_ctrl_pkg::*;

module src_reg_decode (
  input  logic [15:0] instr,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        uses_rd_src,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [3:0]  rd
);
  opcode_t op;

  assign op = opcode_t'(instr[15:12]);
  assign rd = instr[11:8];
  assign rs = instr[7:4];
  assign rt = instr[3:0];

  // Shift/rotate ops carry an immediate in [3:0]; SW/LLB/LHB read [11:8].
  always_comb begin
    uses_rs     = 1'b0;
    uses_rt     = 1'b0;
    uses_rd_src = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR, OP_LW, OP_BR: uses_rs = 1'b1;
      OP_SW: begin
        uses_rs     = 1'b1;
        uses_rd_src = 1'b1;
      end
      OP_LLB, OP_LHB: uses_rd_src = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard and stall controller: load-use and flag-hazard
// bubbles, memory-stall freeze, HLT handling and a saturating stall counter.
import id_hazard_ctrl_pkg::*;

module id_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  id_hazard_ctrl_if.slave   bus
);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  opcode_t          op;
  logic             uses_rs, uses_rt, uses_rd_src;
  logic [3:0]       rs, rt, rd;
  logic             src_match, load_use, flag_haz, hlt_id;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_noop, halted;

  src_reg_decode u_decode (
    .instr       (bus.instr_id),
    .uses_rs     (uses_rs),
    .uses_rt     (uses_rt),
    .uses_rd_src (uses_rd_src),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd)
  );

  assign op = opcode_t'(bus.instr_id[15:12]);

  // The SW data register is forwarded MEM->MEM, so only non-SW [11:8] reads count.
  assign src_match = (bus.reg_addr_ex != 4'd0) &&
                     ((uses_rs && rs == bus.reg_addr_ex) ||
                      (uses_rt && rt == bus.reg_addr_ex) ||
                      (uses_rd_src && op != OP_SW && rd == bus.reg_addr_ex));
  assign load_use  = ~bus.noop_id & bus.mem_read_ex & ~bus.noop_ex & src_match;
  assign flag_haz  = ~bus.noop_id & reads_flags(op) & bus.flag_set_ex & ~bus.noop_ex;
  assign hlt_id    = ~bus.noop_id & (op == OP_HLT);

  // Next state and pipeline controls; MEM_WAIT falls through to the RUN rules
  // as soon as mem_busy drops so no extra bubble is spent on the way out.
  always_comb begin
    state_nxt  = state;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_noop  = 1'b0;
    halted     = 1'b0;
    if (state == HALTED) begin
      halted    = 1'b1;
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = ~bus.mem_busy;
      idex_noop = 1'b1;
    end else if (bus.mem_busy) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      state_nxt = MEM_WAIT;
    end else begin
      state_nxt = RUN;
      if (load_use || flag_haz) begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_noop = 1'b1;
      end else if (hlt_id) begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        state_nxt = HALTED;
      end else if (bus.br_taken_id) begin
        ifid_flush = 1'b1;
      end
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Stall-cycle counter: counts frozen-PC cycles outside HALTED, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (state != HALTED && !pc_en && cnt != {CNT_W{1'b1}})
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign bus.pc_en      = pc_en;
  assign bus.ifid_en    = ifid_en;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_en    = idex_en;
  assign bus.idex_noop  = idex_noop;
  assign bus.halted     = halted;
  assign bus.stall_cnt  = cnt;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl. A 4-bit stall counter keeps the
// saturation case short.
module tb_id_hazard_ctrl;
  localparam int CNT_W = 4;
  // Control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_noop, halted}
  localparam logic [5:0] C_RUN     = 6'b110100;
  localparam logic [5:0] C_BUB     = 6'b000110;
  localparam logic [5:0] C_FRZ     = 6'b000000;
  localparam logic [5:0] C_FLUSH   = 6'b111100;
  localparam logic [5:0] C_HLT     = 6'b000100;
  localparam logic [5:0] C_HALTED  = 6'b000111;
  localparam logic [5:0] C_HALT_MB = 6'b000011;
  localparam logic [15:0] I_IDLE   = 16'h0123;  // ADD R1,R2,R3

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [5:0] ctl;

  id_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  id_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign ctl = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_noop, bus.halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [15:0] ins, input logic nid, input logic [3:0] ra,
                     input logic mr, input logic fs, input logic nex,
                     input logic br, input logic mb);
    bus.instr_id    = ins;
    bus.noop_id     = nid;
    bus.reg_addr_ex = ra;
    bus.mem_read_ex = mr;
    bus.flag_set_ex = fs;
    bus.noop_ex     = nex;
    bus.br_taken_id = br;
    bus.mem_busy    = mb;
  endtask

  // Drive at the falling edge, check controls and counter, then cross one rising edge.
  task automatic vec(input string tag, input logic [15:0] ins, input logic nid,
                     input logic [3:0] ra, input logic mr, input logic fs,
                     input logic nex, input logic br, input logic mb,
                     input logic [5:0] ectl, input int ecnt);
    drv(ins, nid, ra, mr, fs, nex, br, mb);
    #2;
    chk({tag, "_ctl"}, 32'(ctl), 32'(ectl));
    chk({tag, "_cnt"}, 32'(bus.stall_cnt), 32'(ecnt));
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic mb, input logic [5:0] ectl, input int ecnt);
    vec(tag, I_IDLE, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, mb, ectl, ecnt);
  endtask

  initial begin
    drv(I_IDLE, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    idle("reset", 1'b0, C_RUN, 0);
    rst_n = 1'b1;

    // Load-use and source decode
    vec("lu_add",   16'h0534, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_BUB, 0);
    idle("lu_after", 1'b0, C_RUN, 1);
    vec("sw_data",  16'h9360, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 1);
    vec("sw_base",  16'h9630, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_BUB, 1);
    vec("llb",      16'hA312, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_BUB, 2);
    vec("sll_imm",  16'h4563, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 3);
    vec("red_rt",   16'h3563, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_BUB, 3);
    vec("noop_id",  16'h0534, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 4);
    vec("noop_ex",  16'h0534, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_RUN, 4);

    // Flag hazards and branch flush
    vec("b_flag",   16'hC000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, C_BUB, 4);
    vec("b_flush",  16'hC000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FLUSH, 5);
    vec("br_flag",  16'hD010, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_BUB, 5);
    vec("alu_flag", I_IDLE,   1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 6);
    vec("r0",       16'h0100, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 6);

    // Memory stall over a load-use hazard, then the bubble
    for (int i = 0; i < 3; i++)
      vec("mb_lu",  16'h0534, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_FRZ, 6 + i);
    vec("mb_bub",   16'h0534, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_BUB, 9);
    idle("mb_done", 1'b0, C_RUN, 10);
    idle("mb_one",  1'b1, C_FRZ, 10);
    idle("mb_exit", 1'b0, C_RUN, 11);

    // Saturation
    for (int i = 0; i < 6; i++)
      idle("sat", 1'b1, C_FRZ, (11 + i > 15) ? 15 : 11 + i);
    drv(I_IDLE, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    chk("sat_hold", 32'(bus.stall_cnt), 32'd15);

    // Asynchronous reset in the middle of a memory stall
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("arst_mb_ctl", 32'(ctl), 32'(C_FRZ));
    drv(I_IDLE, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("arst_ctl", 32'(ctl), 32'(C_RUN));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // HLT
    vec("hlt",      16'hF000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_HLT, 0);
    idle("halt1",   1'b0, C_HALTED, 1);
    idle("halt2",   1'b0, C_HALTED, 1);
    idle("halt_mb", 1'b1, C_HALT_MB, 1);
    idle("halt3",   1'b0, C_HALTED, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("halt_rst_ctl", 32'(ctl), 32'(C_RUN));
    chk("halt_rst_cnt", 32'(bus.stall_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
